// File: rtl/disp_pkg.sv
// Shared definitions for the multi-field 7-segment display sequencer:
// display modes, FSM states, segment patterns and a parameter-check helper.
package disp_pkg;

   typedef enum logic [1:0] {
      MODE_UDEC = 2'b00,
      MODE_HEX  = 2'b01,
      MODE_SDEC = 2'b10,
      MODE_RSVD = 2'b11   // decodes as unsigned decimal
   } mode_e;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      STORE
   } state_e;

   localparam logic [6:0] MINUS     = 7'h40;
   localparam logic [6:0] BLANK_SEG = 7'h00;

   // bit0 = segment a ... bit6 = segment g, active-high
   localparam logic [6:0] DIGIT_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [63:0] ipow(input int unsigned base, input int unsigned e);
      logic [63:0] r;
      r = 64'd1;
      for (int unsigned i = 0; i < e; i++) r = r * 64'(base);
      return r;
   endfunction

endpackage

// File: rtl/seg7_digit.sv
// One 7-segment digit encoder: minus overrides blank, blank overrides the value.
module seg7_digit
   import disp_pkg::*;
(
   input  logic [3:0] value,
   input  logic       blank,
   input  logic       minus,
   output logic [6:0] seg
);

   always_comb begin
      if (minus)      seg = MINUS;
      else if (blank) seg = BLANK_SEG;
      else            seg = DIGIT_SEG[value];
   end

endmodule

// File: rtl/field_display_seq.sv
// Sweeps NFIELD binary fields through one shared shift/add-3 converter and
// latches their encoded 7-segment digits, re-sweeping whenever {dip,mode} change.
module field_display_seq
   import disp_pkg::*;
#(
   parameter int NFIELD = 2,
   parameter int FW     = 5,
   parameter int NDIG   = 3,
   parameter int BLANK  = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NFIELD*FW-1:0]     dip,
   input  logic [1:0]               mode,
   output logic [NFIELD*NDIG*7-1:0] display,
   output logic                     busy,
   output logic                     done
);

   localparam int IW = (NFIELD > 1) ? $clog2(NFIELD) : 1;
   localparam int CW = $clog2(FW + 1);
   localparam int DW = NDIG * 4;
   localparam logic [IW-1:0] LAST_IDX = IW'(NFIELD - 1);
   localparam logic [CW-1:0] FW_CNT   = CW'(FW);

   if (ipow(10, NDIG) <= (64'd1 << FW)) begin : g_bad_udec
      $error("NDIG decimal digits cannot hold an unsigned FW-bit field");
   end
   if (ipow(10, NDIG - 1) < (64'd1 << (FW - 1))) begin : g_bad_sdec
      $error("NDIG-1 decimal digits cannot hold a signed FW-bit magnitude");
   end
   if (4 * NDIG < FW) begin : g_bad_hex
      $error("NDIG hex digits cannot hold an FW-bit field");
   end

   state_e                 state, state_nxt;
   logic [NFIELD*FW-1:0]   snap_dip;
   logic [1:0]             snap_mode;
   logic                   snap_valid;
   logic [IW-1:0]          idx;
   logic [FW-1:0]          sr;
   logic [DW-1:0]          bcd, bcd_adj;
   logic [CW-1:0]          bitcnt;
   logic                   neg;
   logic                   changed, is_hex, is_signed;
   logic [FW-1:0]          field;
   logic [NDIG*7-1:0]      enc;
   logic [NDIG-1:0]        blank_d, minus_d;

   assign changed   = !snap_valid || (dip != snap_dip) || (mode != snap_mode);
   assign is_hex    = (mode_e'(snap_mode) == MODE_HEX);
   assign is_signed = (mode_e'(snap_mode) == MODE_SDEC);
   assign field     = snap_dip[idx*FW +: FW];
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (changed) state_nxt = LOAD;
         LOAD:    state_nxt = SHIFT;
         SHIFT:   if (bitcnt == CW'(1)) state_nxt = STORE;
         STORE:   state_nxt = (idx == LAST_IDX) ? IDLE : LOAD;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bcd_adj = bcd;
      if (!is_hex) begin
         for (int k = 0; k < NDIG; k++) begin
            if (bcd[k*4 +: 4] >= 4'd5) bcd_adj[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments; the display register is
   // reset explicitly because it is a visible output, not scratch storage.
   always_ff @(posedge clk) begin
      if (reset) begin
         snap_dip   <= '0;
         snap_mode  <= '0;
         snap_valid <= 1'b0;
         idx        <= '0;
         sr         <= '0;
         bcd        <= '0;
         bitcnt     <= '0;
         neg        <= 1'b0;
         display    <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (changed) begin
                  snap_dip   <= dip;
                  snap_mode  <= mode;
                  snap_valid <= 1'b1;
                  idx        <= '0;
               end
            end
            LOAD: begin
               bcd    <= '0;
               bitcnt <= FW_CNT;
               neg    <= is_signed && field[FW-1];
               sr     <= (is_signed && field[FW-1]) ? -field : field;
            end
            SHIFT: begin
               {bcd, sr} <= {bcd_adj, sr} << 1;
               bitcnt    <= bitcnt - CW'(1);
            end
            STORE: begin
               display[idx*NDIG*7 +: NDIG*7] <= enc;
               if (idx == LAST_IDX) done <= 1'b1;
               else                 idx  <= idx + IW'(1);
            end
            default: ;
         endcase
      end
   end

   // Leading-zero blanking looks at all digits from position k upward.
   for (genvar k = 0; k < NDIG; k++) begin : g_digit
      if (k == 0) begin : g_lsd
         assign blank_d[k] = 1'b0;
      end else begin : g_upper
         assign blank_d[k] = (BLANK != 0) && (bcd[DW-1:k*4] == '0);
      end
      assign minus_d[k] = (k == NDIG - 1) && neg;

      seg7_digit u_digit (
         .value (bcd[k*4 +: 4]),
         .blank (blank_d[k]),
         .minus (minus_d[k]),
         .seg   (enc[k*7 +: 7])
      );
   end

endmodule

// File: doc/field_display_seq.md
FIELD_DISPLAY_SEQ -- requirements
Module: field_display_seq

Interface
REQ-001 SHALL have parameter NFIELD, default 2: number of input fields.
REQ-002 SHALL have parameter FW, default 5: bits per field.
REQ-003 SHALL have parameter NDIG, default 3: 7-segment digits per field.
REQ-004 SHALL have parameter BLANK, default 1: 1 = blank leading zeros (digit 0 never blanked).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port dip  input  NFIELD*FW  fields; field i = dip[i*FW +: FW].
REQ-008 SHALL have port mode  input  2  00 unsigned decimal, 01 hex, 10 signed decimal (two's complement), 11 treated as 00.
REQ-009 SHALL have port display  output  NFIELD*NDIG*7  digit k of field i = display[(i*NDIG+k)*7 +: 7], k=0 least significant; bit0=a..bit6=g, active-high.
REQ-010 SHALL have port busy  output  1  high while a conversion sweep is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a sweep completes.

Function
REQ-012 SHALL use FSM states IDLE, LOAD, SHIFT, STORE; busy = (state != IDLE).
REQ-013 In IDLE, if snapshot invalid or {dip,mode} differs from the snapshot, SHALL capture {dip,mode}, set field index 0, go to LOAD; otherwise stay in IDLE.
REQ-014 LOAD SHALL clear the digit register and load the field into the shift register (signed mode: magnitude, sign flag kept), bit counter = FW.
REQ-015 SHALL stay in SHIFT exactly FW cycles, shifting one bit per cycle; decimal modes apply add-3 to every digit >= 5 before each shift; hex mode shifts with no correction.
REQ-016 STORE SHALL write encoded digits of the current field into display; if index = NFIELD-1 go to IDLE, else increment index and go to LOAD.
REQ-017 Latency: capture in IDLE at cycle t -> done high and final display valid at cycle t+1+NFIELD*(FW+2) (15 for defaults).
REQ-018 done SHALL be high only in the first IDLE cycle after the final STORE.
REQ-019 Fields not yet stored SHALL hold previous display values (no intermediate/flicker values).
REQ-020 dip/mode changes during a sweep SHALL NOT abort it; the following IDLE cycle detects the mismatch and starts a new sweep (done and capture in the same cycle).
REQ-021 Encodings: 0-9 and A-F standard (0=0x3F, 1=0x06, 3=0x4F, 6=0x7D, A=0x77), minus=0x40, blank=0x00.
REQ-022 With BLANK=1, zero digits above the most significant nonzero digit SHALL be 0x00.
REQ-023 Signed mode, negative value: digit NDIG-1 SHALL show minus (overriding its contents); non-negative shows normal digits.
REQ-024 Parameters SHALL satisfy 10^NDIG > 2^FW (unsigned), 10^(NDIG-1) >= 2^(FW-1) (signed), 16^NDIG >= 2^FW (hex); violation SHALL be an elaboration error.

Reset
REQ-025 reset SHALL force state IDLE, display all 0x00, busy 0, done 0, snapshot invalid, index 0.
REQ-026 reset asserted mid-sweep SHALL discard the sweep; first cycle after release starts a fresh capture.

Structure
REQ-027 Shared package disp_pkg SHALL hold mode encodings, FSM state enum, segment constants (digit table, MINUS, BLANK_SEG).
REQ-028 SHALL instantiate one sub-module seg7_digit (4-bit value + blank + minus -> 7 segments), one per digit position.
REQ-029 Only one shift/add-3 datapath SHALL exist, time-shared across fields.

Verification
REQ-030 Reset release, dip=10'b11111_00000, mode=00 -> done at cycle 15; field1 digits {0x00,0x4F,0x06}, field0 {0x00,0x00,0x3F}.
REQ-031 mode=01, field1=5'h1A -> field1 digits {0x00,0x06,0x77}.
REQ-032 mode=10, field0=5'b10000 -> {0x40,0x06,0x7D}; field0=5'b11111 -> {0x40,0x00,0x06}.
REQ-033 dip change at capture+3 -> first done at 15 with old values, second capture at 15, second done at 30 with new values.
REQ-034 reset pulsed during SHIFT -> next cycle display all 0, busy 0, done 0; full sweep completes 15 cycles after release.
REQ-035 mode toggled 00->01 with dip constant -> new sweep starts, done after 15 cycles, display reflects hex.
